// File: rtl/pipe_in_fifo.sv
// Elastic valid/ready input buffer for the pipe_pal stage, with first-word fall-through and synchronous flush.
// Optional high-water-mark output o_hwm is enabled by defining PIPE_IN_FIFO_HWM_EN.
module pipe_in_fifo #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 8,
  localparam int W_CNT = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_DATA-1:0] o_data,
  input  logic              i_flush,
`ifdef PIPE_IN_FIFO_HWM_EN
  output logic [W_CNT-1:0]  o_hwm,
`endif
  output logic [W_CNT-1:0]  o_count
);

  localparam int W_PTR = $clog2(DEPTH);

  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_PTR-1:0]  wr_ptr;
  logic [W_PTR-1:0]  rd_ptr;
  logic [W_CNT-1:0]  count;
  logic [W_CNT-1:0]  count_nxt;
  logic              push;
  logic              pop;

  assign o_ready = (count != W_CNT'(DEPTH));
  assign o_valid = (count != '0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  assign o_count = count;

  // Gate on o_valid so the unreset storage never leaks to o_data after reset or while empty.
  assign o_data  = o_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    if (i_flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_flush)
      mem[wr_ptr] <= i_data;
  end

`ifdef PIPE_IN_FIFO_HWM_EN
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn)
      o_hwm <= '0;
    else if (i_flush)
      o_hwm <= '0;
    else if (count_nxt > o_hwm)
      o_hwm <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_pipe_in_fifo.sv
// Directed self-checking bench for pipe_in_fifo (DEPTH=8, W_DATA=32); covers the optional o_hwm when enabled.
module tb_pipe_in_fifo;

  localparam int W_DATA = 32;
  localparam int DEPTH  = 8;
  localparam int W_CNT  = $clog2(DEPTH) + 1;

  logic              i_clk;
  logic              resetn;
  logic              i_valid;
  logic              o_ready;
  logic [W_DATA-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [W_DATA-1:0] o_data;
  logic              i_flush;
  logic [W_CNT-1:0]  o_count;
`ifdef PIPE_IN_FIFO_HWM_EN
  logic [W_CNT-1:0]  o_hwm;
`endif

  int unsigned total;
  int unsigned bad;

  pipe_in_fifo #(.W_DATA(W_DATA), .DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .resetn  (resetn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .i_flush (i_flush),
`ifdef PIPE_IN_FIFO_HWM_EN
    .o_hwm   (o_hwm),
`endif
    .o_count (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_data = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, o_ready); end
      total++; if (o_count !== 4'd0) begin bad++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, o_count); end
      total++; if (o_data !== 32'd0) begin bad++; $display("FAIL reset_data cyc=%0d got=%h exp=0", i, o_data); end
`ifdef PIPE_IN_FIFO_HWM_EN
      total++; if (o_hwm !== 4'd0) begin bad++; $display("FAIL reset_hwm cyc=%0d got=%0d exp=0", i, o_hwm); end
`endif
    end
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 4'd0) begin
        bad++; $display("FAIL idle cyc=%0d valid=%b ready=%b count=%0d exp 0/1/0", i, o_valid, o_ready, o_count);
      end
    end
  endtask

  task automatic test_single();
    i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_ready = 1'b0;
    step();
    i_valid = 1'b0; i_data = '0;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", o_valid); end
    total++; if (o_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", o_count); end
    for (int i = 0; i < 4; i++) begin
      total++; if (o_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_hold cyc=%0d got=%h exp=deadbeef", i, o_data); end
      step();
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    total++; if (o_count !== 4'd0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL single_pop count=%0d valid=%b exp 0/0", o_count, o_valid);
    end
  endtask

  task automatic test_fill();
    i_ready = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      i_valid = 1'b1; i_data = 32'(v);
      step();
    end
    total++; if (o_count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", o_count); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", o_ready); end
    i_data = 32'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (o_count !== 4'd8 || o_ready !== 1'b0 || o_data !== 32'd1) begin
        bad++; $display("FAIL full_stall cyc=%0d count=%0d ready=%b data=%0d exp 8/0/1", i, o_count, o_ready, o_data);
      end
    end
    i_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      int unsigned exp_cnt;
      exp_cnt = (k == 1) ? 8 : (k == 2) ? 7 : 10 - k;
      total++; if (o_data !== 32'(k)) begin bad++; $display("FAIL drain_data k=%0d got=%0d exp=%0d", k, o_data, k); end
      total++; if (o_count !== W_CNT'(exp_cnt)) begin bad++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, o_count, exp_cnt); end
      total++; if (o_ready !== (k != 1)) begin bad++; $display("FAIL drain_ready k=%0d got=%b exp=%b", k, o_ready, k != 1); end
      step();
      if (k == 2) i_valid = 1'b0;
    end
    i_ready = 1'b0;
    total++; if (o_count !== 4'd0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty count=%0d valid=%b exp 0/0", o_count, o_valid);
    end
  endtask

  task automatic test_stream();
    i_valid = 1'b1; i_data = 32'd100; i_ready = 1'b0;
    step();
    i_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] exp_head;
      exp_head = (i == 0) ? 32'd100 : 32'(i - 1);
      i_data = 32'(i);
      total++; if (o_data !== exp_head || o_count !== 4'd1) begin
        bad++; $display("FAIL stream i=%0d data=%0d count=%0d exp %0d/1", i, o_data, o_count, exp_head);
      end
      step();
    end
    i_valid = 1'b0;
    total++; if (o_data !== 32'd19 || o_count !== 4'd1) begin
      bad++; $display("FAIL stream_tail data=%0d count=%0d exp 19/1", o_data, o_count);
    end
    step();
    i_ready = 1'b0;
    total++; if (o_count !== 4'd0) begin bad++; $display("FAIL stream_empty got=%0d exp=0", o_count); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      i_valid = 1'b1; i_data = 32'(50 + v);
      step();
    end
    total++; if (o_count !== 4'd5 || o_data !== 32'd50) begin
      bad++; $display("FAIL flush_pre count=%0d data=%0d exp 5/50", o_count, o_data);
    end
`ifdef PIPE_IN_FIFO_HWM_EN
    total++; if (o_hwm !== 4'd8) begin bad++; $display("FAIL hwm_pre_flush got=%0d exp=8", o_hwm); end
`endif
    i_valid = 1'b1; i_data = 32'h2A; i_ready = 1'b1; i_flush = 1'b1;
    step();
    i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    total++; if (o_count !== 4'd0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL flush_clear count=%0d valid=%b ready=%b exp 0/0/1", o_count, o_valid, o_ready);
    end
`ifdef PIPE_IN_FIFO_HWM_EN
    total++; if (o_hwm !== 4'd0) begin bad++; $display("FAIL hwm_flush got=%0d exp=0", o_hwm); end
`endif
    i_valid = 1'b1; i_data = 32'd7;
    step();
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b1 || o_data !== 32'd7 || o_count !== 4'd1) begin
      bad++; $display("FAIL flush_next valid=%b data=%0d count=%0d exp 1/7/1", o_valid, o_data, o_count);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int v = 0; v < 4; v++) begin
      i_valid = 1'b1; i_data = 32'(200 + v);
      step();
    end
    i_valid = 1'b0;
    total++; if (o_count !== 4'd4 || o_data !== 32'd200) begin
      bad++; $display("FAIL mid_pre count=%0d data=%0d exp 4/200", o_count, o_data);
    end
`ifdef PIPE_IN_FIFO_HWM_EN
    total++; if (o_hwm !== 4'd4) begin bad++; $display("FAIL hwm_pre_reset got=%0d exp=4", o_hwm); end
`endif
    #2 resetn = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_count !== 4'd0 || o_ready !== 1'b1 || o_data !== 32'd0) begin
      bad++; $display("FAIL mid_reset valid=%b count=%0d ready=%b data=%h exp 0/0/1/0", o_valid, o_count, o_ready, o_data);
    end
`ifdef PIPE_IN_FIFO_HWM_EN
    total++; if (o_hwm !== 4'd0) begin bad++; $display("FAIL hwm_reset got=%0d exp=0", o_hwm); end
`endif
    step();
    resetn = 1'b1;
    step();
    total++; if (o_valid !== 1'b0 || o_count !== 4'd0) begin
      bad++; $display("FAIL mid_after valid=%b count=%0d exp 0/0", o_valid, o_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_in_fifo.md
Name: pipe_in_fifo

Overview:
- Elastic input buffer that sits directly upstream of the pipe_pal datapath stage.
- Accepts W_DATA-wide words from a producer over a valid/ready handshake and stores up to DEPTH words.
- Presents the words in order to pipe_pal over a second valid/ready handshake, decoupling producer stalls from pipeline back-pressure.
- Also provides a synchronous flush, used when the pipeline is aborted.

Parameters:
- W_DATA, 32, data word width in bits.
- DEPTH, 8, number of storage entries; power of two, minimum 2.
- W_CNT (localparam), $clog2(DEPTH)+1, width of occupancy count.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  FIFO can accept a word.
- i_data  input  W_DATA  upstream word.
- o_valid  output  1  head word available to pipe_pal.
- i_ready  input  1  pipe_pal accepts the head word.
- o_data  output  W_DATA  head word.
- i_flush  input  1  synchronous discard of all contents.
- o_count  output  W_CNT  current occupancy, 0..DEPTH.

Behaviour:
- Reset (resetn=0, asynchronous assert, synchronous deassert handled externally):
  - Write pointer, read pointer and count cleared to 0.
  - o_valid=0, o_ready=1, o_count=0, o_data=0.
  - Storage array is not reset.
- Transfer definitions:
  - Push occurs when i_valid && o_ready at a rising edge.
  - Pop occurs when o_valid && i_ready at a rising edge.
- Output decode:
  - o_ready = (count != DEPTH), decoded from registered count. No same-cycle dependency on i_ready, so there is no combinational path from pop to o_ready.
  - o_valid = (count != 0), decoded from registered count.
  - o_data = mem[rd_ptr] (first-word fall-through). Must be stable while o_valid=1 and no pop occurs.
- Latency: a word pushed into an empty FIFO appears on o_valid/o_data on the following cycle. There is no same-cycle bypass.
- Pointers:
  - Each pointer is $clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
  - wr_ptr increments on push; rd_ptr increments on pop.
- Count update per cycle: push only → +1; pop only → -1; both → unchanged; neither → unchanged.
- Full (count=DEPTH):
  - o_ready=0, so i_valid is ignored and no push occurs.
  - A pop in the same cycle frees a slot, but o_ready only rises the next cycle.
- Empty (count=0): o_valid=0, i_ready is ignored, and no underflow occurs.
- Simultaneous push and pop with count in 1..DEPTH-1: both complete; the head advances and the new word is written at wr_ptr.
- Flush:
  - i_flush=1 at an edge clears wr_ptr, rd_ptr and count, and takes priority over push/pop in that cycle.
  - A word offered in the flush cycle is discarded. The producer must treat it as accepted if o_ready was 1.
  - Next cycle: o_valid=0, o_ready=1.
- Reset mid-operation: all stored words are lost and the outputs return to their reset values immediately.
- Implementation intent: no latches; count must never exceed DEPTH or underflow 0.

Optional Feature:
- Macro: PIPE_IN_FIFO_HWM_EN.
- When defined:
  - Adds output o_hwm (W_CNT bits), the maximum o_count observed since reset or flush.
  - Updated on the same edge as count, so it equals the new count when that exceeds the previous o_hwm.
  - Reset to 0; a flush clears it to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: resetn low 3 cycles, release, i_valid=0 for 5 cycles → o_valid=0, o_ready=1, o_count=0 throughout.
- Single word: push 32'hDEAD_BEEF with i_ready=0 → next cycle o_valid=1, o_data=32'hDEAD_BEEF, o_count=1; hold 4 cycles, data stable; then i_ready=1 for 1 cycle → o_count=0, o_valid=0.
- Fill to full (DEPTH=8): push 1..8 with i_ready=0 → o_count=8, o_ready=0; keep i_valid=1 with 9 for 3 cycles → no change; then pop → o_data sequence 1..8 in order, and 9 is pushed only after o_ready returns to 1.
- Streaming wrap: i_valid=i_ready=1 continuously for 20 words 0..19 after one preload word → o_count stays 1, output order is preserved across pointer wrap, and nothing is lost or duplicated.
- Flush: preload 5 words, assert i_flush together with a push of 6'h2A and a pop → next cycle o_count=0, o_valid=0, o_ready=1; a subsequent push of 7 appears as the next head.
- Reset mid-stream: 4 words stored, resetn pulsed low between edges → o_valid=0 and o_count=0 immediately; with PIPE_IN_FIFO_HWM_EN, o_hwm=0 after reset and o_hwm=4 before it.
